// File: rtl/mips_multicycle_ctrl.sv
// Control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute/memory/writeback
// over one shared ALU and one shared SRAM, driving every datapath select, write enable and SRAM strobe.
module mips_multicycle_ctrl #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       stall,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       IRWrite,
  output logic [1:0] MemToReg,
  output logic [1:0] RegDST,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       CEN,
  output logic       OEN,
  output logic       WEN,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_JAL    = 4'd10,
    S_JR     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [3:0] LAST_HOLD = 4'(MEM_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       store_q, store_d;
  logic       last_hold;
  logic       op_known;

  assign last_hold = (wait_q == LAST_HOLD);
  assign op_known  = opcode inside {OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_LW, OP_SW};
  assign state     = state_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      store_q <= store_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    store_d = store_q;
    if (!stall) begin
      unique case (state_q)
        S_FETCH:  if (last_hold) state_d = S_DECODE;
        S_DECODE: begin
          // The lw/sw distinction is captured here since opcode is only trusted in DECODE.
          store_d = (opcode == OP_SW);
          case (opcode)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = (funct == FN_JR) ? S_JR : S_EXEC;
            OP_BEQ:       state_d = S_BRANCH;
            OP_J:         state_d = S_JUMP;
            OP_JAL:       state_d = S_JAL;
            default:      state_d = S_FETCH;
          endcase
        end
        S_MEMADR: state_d = store_q ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (last_hold) state_d = S_MEMWB;
        S_MEMWR:  if (last_hold) state_d = S_FETCH;
        S_EXEC:   state_d = S_RWB;
        default:  state_d = S_FETCH;
      endcase
      // Only memory states ever stay put, so the counter runs there and clears on any exit.
      wait_d = (state_d == state_q) ? wait_q + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 2'b00;
    RegDST      = 2'b00;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    CEN         = 1'b1;
    OEN         = 1'b1;
    WEN         = 1'b1;
    illegal     = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        S_FETCH: begin
          CEN = 1'b0;
          OEN = 1'b0;
          if (last_hold) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            ALUSrcB = 2'b01;
          end
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          illegal = !op_known;
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          IorD = 1'b1;
          CEN  = 1'b0;
          OEN  = 1'b0;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemToReg = 2'b01;
        end
        S_MEMWR: begin
          IorD = 1'b1;
          CEN  = 1'b0;
          WEN  = 1'b0;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_RWB: begin
          RegWrite = 1'b1;
          RegDST   = 2'b01;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        S_JAL: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
          RegWrite = 1'b1;
          RegDST   = 2'b10;
          MemToReg = 2'b10;
        end
        S_JR: begin
          PCWrite  = 1'b1;
          PCSource = 2'b11;
        end
        default: ;
      endcase
      // A frozen cycle may not commit anything, but selects and read strobes stay steady.
      if (stall) begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        illegal     = 1'b0;
        WEN         = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: two instances (MEM_LAT 1 and 3), each fed random and
// directed instruction streams; a reference model queues the expected per-cycle output vectors.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       irw;
    logic [1:0] m2r;
    logic [1:0] rdst;
    logic       rw;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aop;
    logic [1:0] psrc;
    logic       cen;
    logic       oen;
    logic       wen;
    logic [3:0] st;
    logic       ill;
  } outs_t;

  logic       clk;
  logic       rst_n_v [2];
  logic       stall_v [2];
  logic [5:0] op_v    [2];
  logic [5:0] fn_v    [2];
  outs_t      act     [2];
  outs_t      exp_q   [2][$];
  int         checks;
  int         errors;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       pcw, pcwc, iord, irw, rw, srca, cen, oen, wen, ill;
    logic [1:0] m2r, rdst, srcb, aop, psrc;
    logic [3:0] st;

    mips_multicycle_ctrl #(.MEM_LAT(g == 0 ? 1 : 3)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n_v[g]),
      .opcode     (op_v[g]),
      .funct      (fn_v[g]),
      .stall      (stall_v[g]),
      .PCWrite    (pcw),
      .PCWriteCond(pcwc),
      .IorD       (iord),
      .IRWrite    (irw),
      .MemToReg   (m2r),
      .RegDST     (rdst),
      .RegWrite   (rw),
      .ALUSrcA    (srca),
      .ALUSrcB    (srcb),
      .ALUOp      (aop),
      .PCSource   (psrc),
      .CEN        (cen),
      .OEN        (oen),
      .WEN        (wen),
      .state      (st),
      .illegal    (ill)
    );

    assign act[g] = {pcw, pcwc, iord, irw, m2r, rdst, rw, srca, srcb, aop, psrc,
                     cen, oen, wen, st, ill};
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lat(input int idx);
    return (idx == 0) ? 1 : 3;
  endfunction

  // Idle vector for a given state: nothing asserted, SRAM strobes high.
  function automatic outs_t base(input logic [3:0] st);
    outs_t v;
    v     = '0;
    v.cen = 1'b1;
    v.oen = 1'b1;
    v.wen = 1'b1;
    v.st  = st;
    return v;
  endfunction

  function automatic outs_t gate(input outs_t v);
    outs_t g;
    g      = v;
    g.pcw  = 1'b0;
    g.pcwc = 1'b0;
    g.irw  = 1'b0;
    g.rw   = 1'b0;
    g.ill  = 1'b0;
    g.wen  = 1'b1;
    return g;
  endfunction

  task automatic check(input string name, input outs_t a, input outs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h (state %0d) expected %h (state %0d) at %0t",
               name, a, a.st, e, e.st, $time);
    end
  endtask

  // Reference model: expands one instruction into the cycle-by-cycle output sequence.
  task automatic push_instr(input int idx, input logic [5:0] op, input logic [5:0] fn,
                            output int n);
    outs_t v;
    int    l;
    l = lat(idx);
    n = 0;
    for (int c = 0; c < l; c++) begin
      v     = base(4'd0);
      v.cen = 1'b0;
      v.oen = 1'b0;
      if (c == l - 1) begin
        v.irw  = 1'b1;
        v.pcw  = 1'b1;
        v.srcb = 2'b01;
      end
      exp_q[idx].push_back(v); n++;
    end
    v      = base(4'd1);
    v.srcb = 2'b11;
    v.ill  = !(op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h23, 6'h2B});
    exp_q[idx].push_back(v); n++;
    if (op == 6'h23 || op == 6'h2B) begin
      v      = base(4'd2);
      v.srca = 1'b1;
      v.srcb = 2'b10;
      exp_q[idx].push_back(v); n++;
      for (int c = 0; c < l; c++) begin
        v      = base((op == 6'h23) ? 4'd3 : 4'd5);
        v.iord = 1'b1;
        v.cen  = 1'b0;
        if (op == 6'h23) v.oen = 1'b0;
        else             v.wen = 1'b0;
        exp_q[idx].push_back(v); n++;
      end
      if (op == 6'h23) begin
        v     = base(4'd4);
        v.rw  = 1'b1;
        v.m2r = 2'b01;
        exp_q[idx].push_back(v); n++;
      end
    end else if (op == 6'h00 && fn == 6'h08) begin
      v      = base(4'd11);
      v.pcw  = 1'b1;
      v.psrc = 2'b11;
      exp_q[idx].push_back(v); n++;
    end else if (op == 6'h00) begin
      v      = base(4'd6);
      v.srca = 1'b1;
      v.aop  = 2'b10;
      exp_q[idx].push_back(v); n++;
      v      = base(4'd7);
      v.rw   = 1'b1;
      v.rdst = 2'b01;
      exp_q[idx].push_back(v); n++;
    end else if (op == 6'h04) begin
      v      = base(4'd8);
      v.srca = 1'b1;
      v.aop  = 2'b01;
      v.pcwc = 1'b1;
      v.psrc = 2'b01;
      exp_q[idx].push_back(v); n++;
    end else if (op == 6'h02 || op == 6'h03) begin
      v      = base((op == 6'h02) ? 4'd9 : 4'd10);
      v.pcw  = 1'b1;
      v.psrc = 2'b10;
      if (op == 6'h03) begin
        v.rw   = 1'b1;
        v.rdst = 2'b10;
        v.m2r  = 2'b10;
      end
      exp_q[idx].push_back(v); n++;
    end
  endtask

  // Runs one instruction; opcode/funct are garbage except in the DECODE cycle.
  task automatic run_instr(input int idx, input logic [5:0] op, input logic [5:0] fn,
                           input bit rnd_stall, input int stall_at);
    int n, k, left;
    bit used;
    push_instr(idx, op, fn, n);
    k    = 0;
    left = 0;
    used = 1'b0;
    while (k < n) begin
      if (left > 0) begin
        stall_v[idx] = 1'b1;
        left--;
      end else if (k == stall_at && !used) begin
        stall_v[idx] = 1'b1;
        left = 1;
        used = 1'b1;
      end else begin
        stall_v[idx] = rnd_stall && ($urandom_range(3) == 0);
      end
      if (k == lat(idx)) begin
        op_v[idx] = op;
        fn_v[idx] = fn;
      end else begin
        op_v[idx] = 6'($urandom);
        fn_v[idx] = 6'($urandom);
      end
      @(posedge clk); #1;
      if (!stall_v[idx]) k++;
    end
    stall_v[idx] = 1'b0;
  endtask

  task automatic reset_mid_exec(input int idx);
    int n, l;
    l = lat(idx);
    push_instr(idx, 6'h00, 6'h20, n);
    for (int k = 0; k <= l; k++) begin
      stall_v[idx] = 1'b0;
      op_v[idx]    = (k == l) ? 6'h00 : 6'($urandom);
      fn_v[idx]    = (k == l) ? 6'h20 : 6'($urandom);
      @(posedge clk); #1;
    end
    #1;
    check($sformatf("u%0d exec_before_reset", idx), act[idx], exp_q[idx][0]);
    #1;
    rst_n_v[idx] = 1'b0;
    #1;
    check($sformatf("u%0d reset_async", idx), act[idx], base(4'd0));
    exp_q[idx].delete();
    @(posedge clk); #1;
    rst_n_v[idx] = 1'b1;
  endtask

  task automatic drive(input int idx);
    logic [5:0] dop [8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h03, 6'h00, 6'h02, 6'h3F};
    logic [5:0] dfn [8] = '{6'h20, 6'h04, 6'h08, 6'h03, 6'h10, 6'h08, 6'h00, 6'h00};
    logic [5:0] rfn [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
    logic [5:0] op, fn;
    int         l;
    l = lat(idx);
    for (int i = 0; i < 8; i++) run_instr(idx, dop[i], dfn[i], 1'b0, -1);
    run_instr(idx, 6'h23, 6'h04, 1'b0, (l > 1) ? l + 3 : l + 2);
    for (int i = 0; i < 40; i++) begin
      fn = 6'($urandom);
      case ($urandom_range(9))
        0, 1, 9: begin op = 6'h00; fn = rfn[$urandom_range(5)]; end
        2:       begin op = 6'h00; fn = 6'h08; end
        3:       op = 6'h23;
        4:       op = 6'h2B;
        5:       op = 6'h04;
        6:       op = 6'h02;
        7:       op = 6'h03;
        default: op = 6'($urandom);
      endcase
      run_instr(idx, op, fn, 1'b1, -1);
    end
    reset_mid_exec(idx);
    run_instr(idx, 6'h00, 6'h2A, 1'b1, -1);
    rst_n_v[idx] = 1'b0;
  endtask

  // Monitor: one expected vector per non-stalled cycle; stalled cycles see the gated head entry.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n_v[i]) begin
        check($sformatf("u%0d reset_idle", i), act[i], base(4'd0));
      end else if (exp_q[i].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u%0d scoreboard_empty: got %h, expected nothing at %0t", i, act[i], $time);
      end else if (stall_v[i]) begin
        check($sformatf("u%0d stalled", i), act[i], gate(exp_q[i][0]));
      end else begin
        check($sformatf("u%0d cycle", i), act[i], exp_q[i].pop_front());
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 2; i++) begin
      rst_n_v[i] = 1'b0;
      stall_v[i] = 1'b0;
      op_v[i]    = 6'h00;
      fn_v[i]    = 6'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n_v[0] = 1'b1;
    rst_n_v[1] = 1'b1;
    fork
      drive(0);
      drive(1);
    join
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Control FSM that sequences a multi-cycle version of the team's MIPS datapath: one shared ALU and one shared SRAM, with instruction and data accesses serialized.
- Decodes the opcode and funct fields, steps through fetch, decode, execute, memory and writeback states, and drives every datapath mux and write enable.
- Drives the active-low SRAM strobes CEN, OEN and WEN directly.
- Supports R-type (add, sub, and, or, slt, nor), jr, lw, sw, beq, j and jal.

Parameters:
- MEM_LAT, 1: cycles each memory state (FETCH, MEMRD, MEMWR) is held; legal range 1..15.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26] from the instruction register.
- funct  in  6  IR[5:0].
- stall  in  1  freeze request from the environment.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by ALUzero (beq).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  instruction register load.
- MemToReg  out  2  register-file write data: 00 = ALUOut, 01 = MDR, 10 = PC.
- RegDST  out  2  write register: 00 = rt, 01 = rd, 10 = $31.
- RegWrite  out  1  register-file write.
- ALUSrcA  out  1  ALU A operand: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B operand: 00 = rt, 01 = 4, 10 = signext, 11 = signext<<2.
- ALUOp  out  2  ALU op class: 00 = add, 01 = sub, 10 = funct-decoded.
- PCSource  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs.
- CEN  out  1  SRAM chip enable, active low.
- OEN  out  1  SRAM output enable, active low.
- WEN  out  1  SRAM write enable, active low.
- state  out  4  current state code, for debug.
- illegal  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Reset (asynchronous, active-low):
  - Asserting rst_n low at any time, including mid-instruction, forces state = FETCH and wait counter = 0 immediately.
  - While rst_n is low, every output is inactive: all write enables 0, all selects 0, CEN = OEN = WEN = 1, illegal = 0.
- Outputs are Moore outputs decoded from state (plus the wait counter). Any signal not listed for a state is 0; CEN, OEN and WEN default to 1.
- State codes: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6, RWB = 7, BRANCH = 8, JUMP = 9, JAL = 10, JR = 11.
- Memory states (FETCH, MEMRD, MEMWR) are held for exactly MEM_LAT cycles using the wait counter.
  - CEN stays low for the whole hold.
  - Write enables that complete the access (IRWrite, PCWrite) assert only on the last hold cycle.
  - The counter clears on leaving the state.
- Per-state outputs and transitions:
  - FETCH: IorD = 0, CEN = 0, OEN = 0. On the last hold cycle: IRWrite = 1, PCWrite = 1, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00. Next: DECODE.
  - DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00. Next by opcode:
    - lw (0x23) or sw (0x2B) -> MEMADR.
    - R-type (0x00) with funct 0x08 -> JR.
    - R-type (0x00) with any other funct -> EXEC.
    - beq (0x04) -> BRANCH.
    - j (0x02) -> JUMP.
    - jal (0x03) -> JAL.
    - Any other opcode -> FETCH, with illegal = 1 for this cycle only.
  - MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD: IorD = 1, CEN = 0, OEN = 0, WEN = 1. Next: MEMWB.
  - MEMWB: RegWrite = 1, RegDST = 00, MemToReg = 01. Next: FETCH.
  - MEMWR: IorD = 1, CEN = 0, WEN = 0, OEN = 1. Next: FETCH.
  - EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Next: RWB.
  - RWB: RegWrite = 1, RegDST = 01, MemToReg = 00. Next: FETCH.
  - BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01. Next: FETCH.
  - JUMP: PCWrite = 1, PCSource = 10. Next: FETCH.
  - JAL: PCWrite = 1, PCSource = 10, RegWrite = 1, RegDST = 10, MemToReg = 10. The PC already holds PC+4 from FETCH, so that value is what lands in $31. Next: FETCH.
  - JR: PCWrite = 1, PCSource = 11. Next: FETCH.
- Stall:
  - While stall = 1, state and wait counter hold.
  - PCWrite, PCWriteCond, IRWrite, RegWrite and illegal are forced to 0, and WEN is forced to 1.
  - CEN, OEN and all selects keep their state values.
  - When stall deasserts, the sequence resumes from the held counter value, with no lost or duplicated cycle.
- Instruction latency with MEM_LAT = L:
  - R-type: L+3 cycles.
  - lw: 2L+3 cycles.
  - sw: 2L+2 cycles.
  - beq, j, jal, jr: L+2 cycles.
  - An illegal opcode costs L+1 cycles.
- opcode and funct are sampled only in DECODE; changes in any other state are ignored.

Test Plan:
- Reset, MEM_LAT = 1, IR = 0x00221820 (add $3,$1,$2) -> states 0,1,6,7,0. RegWrite = 1 and RegDST = 01 only in state 7; ALUOp = 10 in state 6; 4 cycles total.
- MEM_LAT = 1, IR = 0x8C220004 (lw) -> states 0,1,2,3,4. In state 3: CEN = 0, OEN = 0, WEN = 1, IorD = 1. In state 4: RegWrite = 1, MemToReg = 01. 5 cycles total.
- MEM_LAT = 3, IR = 0xAC220008 (sw) -> FETCH held 3 cycles with IRWrite only on the 3rd; MEMWR held 3 cycles with WEN = 0 and CEN = 0 on each; 8 cycles total.
- beq 0x10220003 -> BRANCH with PCWriteCond = 1, ALUOp = 01, PCSource = 01. jal 0x0C000010 -> JAL with RegDST = 10, MemToReg = 10, PCSource = 10, PCWrite = 1.
- MEM_LAT = 3, lw, stall = 1 for 2 cycles during the 2nd MEMRD cycle -> state 3 holds, then 2 more MEMRD cycles, then MEMWB; total cycle count grows by exactly 2.
- rst_n pulsed low during EXEC -> state = 0 and all outputs inactive within the same cycle. Separately, opcode 0x3F -> illegal = 1 for one cycle in DECODE, then FETCH.
